// File: rtl/restador_serie_nbits.sv
// ---------------------------------------------------------------------------
// restador_serie_nbits
// Bit-serial N-bit subtractor: D = A - B - Bi, computed LSB-first over N
// clocks with a single full-subtractor cell. Start/busy/done handshake.
//
// Optional feature macro: SUB_OVF_EN (adds the ovf_o port and its logic).
//
// Ports:
//   clk_i     system clock, rising edge
//   rst_i     synchronous reset, active-high
//   start_i   request; accepted only in IDLE or DONE
//   a_i       minuend, latched on accepted start
//   b_i       subtrahend, latched on accepted start
//   bi_i      borrow in, latched on accepted start
//   d_o       difference, updated at DONE entry and held
//   bo_o      borrow out, updated and held like d_o
//   busy_o    high while the serial operation runs
//   done_o    one-cycle pulse when d_o/bo_o become valid
//   ovf_o     signed overflow (SUB_OVF_EN only), held like d_o
// ---------------------------------------------------------------------------
module restador_serie_nbits #(
    parameter int unsigned N = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         bi_i,
    output logic [N-1:0] d_o,
    output logic         bo_o,
    output logic         busy_o,
    output logic         done_o
`ifdef SUB_OVF_EN
    ,
    output logic         ovf_o
`endif
);

    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e           state_q;
    logic [N-1:0]     ra_q;
    logic [N-1:0]     rb_q;
    logic [N-2:0]     res_q;   // upper N-1 result bits collected so far
    logic             br_q;
    logic [CNT_W-1:0] cnt_q;

`ifdef SUB_OVF_EN
    logic             a_msb_q;
    logic             b_msb_q;
`endif

    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             br_d;
    logic [N-1:0]     res_d;
    logic             last_bit;

    // Full-subtractor cell on the current LSBs
    assign a_bit    = ra_q[0];
    assign b_bit    = rb_q[0];
    assign d_bit    = a_bit ^ b_bit ^ br_q;
    assign br_d     = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);

    // New difference bit enters at the MSB; on the last bit res_d is the full result
    assign res_d    = {d_bit, res_q};
    assign last_bit = (cnt_q == CNT_W'(N - 1));

    // Control FSM and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            d_o     <= '0;
            bo_o    <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
`ifdef SUB_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_o   <= 1'b0;
`endif
        end else begin
            done_o <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        ra_q    <= a_i;
                        rb_q    <= b_i;
                        br_q    <= bi_i;
                        res_q   <= '0;
                        cnt_q   <= '0;
                        busy_o  <= 1'b1;
                        state_q <= S_SHIFT;
`ifdef SUB_OVF_EN
                        a_msb_q <= a_i[N-1];
                        b_msb_q <= b_i[N-1];
`endif
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    ra_q  <= ra_q >> 1;
                    rb_q  <= rb_q >> 1;
                    br_q  <= br_d;
                    res_q <= res_d[N-1:1];
                    if (last_bit) begin
                        // Counter parks at 0 so it never exceeds N-1
                        cnt_q   <= '0;
                        state_q <= S_DONE;
                        d_o     <= res_d;
                        bo_o    <= br_d;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
`ifdef SUB_OVF_EN
                        ovf_o   <= (a_msb_q ^ b_msb_q) & (a_msb_q ^ d_bit);
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
